// File: rtl/guard_insert_pkg.sv
// rtl/guard_insert_pkg.sv - shared state encoding, default widths and symbol-length helper
package guard_insert_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PREAMBLE   = 3'd1,
        ST_SYMBOL     = 3'd2,
        ST_GUARD      = 3'd3,
        ST_TAIL_GUARD = 3'd4
    } state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NFFT_W  = 14;
    localparam int DEF_CP_W    = 12;
    localparam int DEF_GUARD_W = 32;
    localparam int DEF_PRE_W   = 16;

    // Samples per symbol: FFT body (nfft holds size-1) plus cyclic prefix.
    function automatic logic [31:0] sym_len_f(input logic [31:0] nfft, input logic [31:0] cp);
        return nfft + 32'd1 + cp;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-stage AXI-Stream output register that holds its beat while stalled
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] in_tdata_i,
    input  logic              in_tvalid_i,
    input  logic              in_tlast_i,
    output logic              in_tready_o,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    output logic              m_tlast_o,
    input  logic              m_tready_i
);

    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;

    assign in_tready_o = !tvalid_q || m_tready_i;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (in_tready_o) begin
            tdata_q  <= in_tdata_i;
            tvalid_q <= in_tvalid_i;
            tlast_q  <= in_tlast_i;
        end
    end

    assign m_tdata_o  = tdata_q;
    assign m_tvalid_o = tvalid_q;
    assign m_tlast_o  = tlast_q;

endmodule

// File: rtl/guard_insert_v2.sv
// rtl/guard_insert_v2.sv - OFDM TX guard inserter; GUARD_INSERT_STATS_EN enables the stats counters
module guard_insert_v2
    import guard_insert_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NFFT_W  = DEF_NFFT_W,
    parameter int CP_W    = DEF_CP_W,
    parameter int GUARD_W = DEF_GUARD_W,
    parameter int PRE_W   = DEF_PRE_W
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    input  logic [NFFT_W-1:0]  i_nfft,
    input  logic [CP_W-1:0]    i_cp_len,
    input  logic [GUARD_W-1:0] i_guard_cycles,
    input  logic [PRE_W-1:0]   i_preamble_len,
    input  logic               i_guard_mode,
    output logic [15:0]        o_symbol_count,
    output logic [15:0]        o_frame_count,
    output logic               o_short_frame
);

    localparam int SL_W  = NFFT_W + 1;
    localparam int CNT_W = (PRE_W > SL_W) ? PRE_W : SL_W;

    state_e             state_q, state_d;
    logic               rdy_en_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GUARD_W-1:0] gcnt_q, gcnt_d;

    logic [NFFT_W-1:0]  nfft_q;
    logic [CP_W-1:0]    cp_q;
    logic [GUARD_W-1:0] guard_q;
    logic [PRE_W-1:0]   pre_q;
    logic               mode_q;

    logic [NFFT_W-1:0]  nfft_c;
    logic [CP_W-1:0]    cp_c;
    logic [GUARD_W-1:0] guard_c;
    logic [PRE_W-1:0]   pre_c;
    logic               mode_c;

    logic               idle, in_stream, in_pre, seg_end, has_guard, guard_last;
    logic               out_rdy, acc;
    logic [SL_W-1:0]    sym_len;
    logic [CNT_W-1:0]   seg_len, cnt_cur;
    logic [DATA_W-1:0]  in_tdata;
    logic               in_tvalid, in_tlast;

    // Live config while idle so the first beat of a frame already uses it; shadow copy afterwards.
    assign idle    = (state_q == ST_IDLE);
    assign nfft_c  = idle ? i_nfft         : nfft_q;
    assign cp_c    = idle ? i_cp_len       : cp_q;
    assign guard_c = idle ? i_guard_cycles : guard_q;
    assign pre_c   = idle ? i_preamble_len : pre_q;
    assign mode_c  = idle ? i_guard_mode   : mode_q;

    assign sym_len    = SL_W'(sym_len_f(32'(nfft_c), 32'(cp_c)));
    assign in_pre     = (state_q == ST_PREAMBLE) || (idle && (pre_c != '0));
    assign seg_len    = in_pre ? CNT_W'(pre_c) : CNT_W'(sym_len);
    assign cnt_cur    = idle ? '0 : cnt_q;
    assign seg_end    = (cnt_cur + CNT_W'(1)) == seg_len;
    assign has_guard  = (guard_c != '0);
    assign guard_last = (gcnt_q == (guard_q - GUARD_W'(1)));

    assign in_stream     = idle || (state_q == ST_PREAMBLE) || (state_q == ST_SYMBOL);
    assign s_axis_tready = in_stream && rdy_en_q && out_rdy;
    assign acc           = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            ST_IDLE, ST_PREAMBLE, ST_SYMBOL: begin
                if (acc) begin
                    cnt_d = cnt_cur + CNT_W'(1);
                    if (s_axis_tlast) begin
                        cnt_d   = '0;
                        gcnt_d  = '0;
                        state_d = has_guard ? ST_TAIL_GUARD : ST_IDLE;
                    end else if (seg_end) begin
                        cnt_d   = '0;
                        gcnt_d  = '0;
                        state_d = (!mode_c && has_guard) ? ST_GUARD : ST_SYMBOL;
                    end else begin
                        state_d = in_pre ? ST_PREAMBLE : ST_SYMBOL;
                    end
                end
            end
            ST_GUARD, ST_TAIL_GUARD: begin
                if (out_rdy) begin
                    gcnt_d = gcnt_q + GUARD_W'(1);
                    if (guard_last) begin
                        state_d = (state_q == ST_GUARD) ? ST_SYMBOL : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_tdata  = '0;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        case (state_q)
            ST_IDLE, ST_PREAMBLE, ST_SYMBOL: begin
                in_tdata  = s_axis_tdata;
                in_tvalid = acc;
                in_tlast  = s_axis_tlast && !has_guard;
            end
            ST_GUARD: begin
                in_tvalid = 1'b1;
            end
            ST_TAIL_GUARD: begin
                in_tvalid = 1'b1;
                in_tlast  = guard_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_en_q <= 1'b0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            nfft_q   <= '0;
            cp_q     <= '0;
            guard_q  <= '0;
            pre_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            if (idle && acc) begin
                nfft_q  <= i_nfft;
                cp_q    <= i_cp_len;
                guard_q <= i_guard_cycles;
                pre_q   <= i_preamble_len;
                mode_q  <= i_guard_mode;
            end
        end
    end

    axis_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_tdata_i  (in_tdata),
        .in_tvalid_i (in_tvalid),
        .in_tlast_i  (in_tlast),
        .in_tready_o (out_rdy),
        .m_tdata_o   (m_axis_tdata),
        .m_tvalid_o  (m_axis_tvalid),
        .m_tlast_o   (m_axis_tlast),
        .m_tready_i  (m_axis_tready)
    );

`ifdef GUARD_INSERT_STATS_EN
    logic [15:0] sym_cnt_q, frame_cnt_q;
    logic        short_q;
    logic        sym_done;

    assign sym_done = acc && !in_pre && seg_end;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sym_cnt_q   <= '0;
            frame_cnt_q <= '0;
            short_q     <= 1'b0;
        end else begin
            if (idle) begin
                sym_cnt_q <= sym_done ? 16'd1 : 16'd0;
            end else if (sym_done) begin
                sym_cnt_q <= sym_cnt_q + 16'd1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            // Any tlast that does not close a full symbol marks the frame as truncated.
            if (acc && s_axis_tlast && !(!in_pre && seg_end)) begin
                short_q <= 1'b1;
            end
        end
    end

    assign o_symbol_count = sym_cnt_q;
    assign o_frame_count  = frame_cnt_q;
    assign o_short_frame  = short_q;
`else
    assign o_symbol_count = 16'd0;
    assign o_frame_count  = 16'd0;
    assign o_short_frame  = 1'b0;
`endif

endmodule
